mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy length of mult/multu in cycles (>=1).
REQ-002 Parameter DIV_CYCLES, default 10, busy length of div/divu in cycles (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 md_op  input  4  E-stage operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none.
REQ-006 start  input  1  E-stage qualifier: md_op is a valid, non-bubble instruction this cycle.
REQ-007 req  input  1  exception/interrupt request this cycle; suppresses all state-changing ops.
REQ-008 A  input  32  E-stage forwarded rs value.
REQ-009 B  input  32  E-stage forwarded rt value.
REQ-010 busy  output  1  registered; high while a mult/div is in flight.
REQ-011 md_out  output  32  combinational: HI when md_op=5, LO when md_op=6, else 0.

Function
REQ-012 Internal state SHALL be: HI[31:0], LO[31:0], cycle counter, pending HI/LO result registers.
REQ-013 An op SHALL be accepted at an edge only when start=1, req=0, busy=0; otherwise it SHALL have no effect on state.
REQ-014 Accepted mult/multu/div/divu SHALL load the counter with MULT_CYCLES/DIV_CYCLES and latch the full result into pending registers at that edge.
REQ-015 busy SHALL equal (counter != 0); counter decrements by 1 every edge while nonzero.
REQ-016 At the edge where counter goes 1->0, HI/LO SHALL take the pending values; busy therefore is high exactly N cycles and HI/LO are new in the first cycle busy=0.
REQ-017 Before that completion edge, HI/LO SHALL retain their pre-op values (md_out reflects old HI/LO).
REQ-018 mult: {HI,LO} = signed(A)*signed(B), 64-bit; multu: unsigned 64-bit product.
REQ-019 div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend A; divu: unsigned quotient/remainder.
REQ-020 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-021 Divide by zero (B=0) SHALL still run DIV_CYCLES busy cycles and SHALL leave HI/LO unchanged at completion.
REQ-022 Accepted mthi/mtlo SHALL write A into HI/LO at that edge, zero latency, busy unaffected.
REQ-023 req=1 while busy SHALL NOT cancel the in-flight operation (its instruction has already committed past M).
REQ-024 mfhi/mflo SHALL never change state; md_out is valid in the same cycle.
REQ-025 Any md_op 1-8 presented while busy=1 is an upstream protocol violation; the block SHALL ignore it and keep the in-flight op intact.
REQ-026 The stall controller SHALL stall D-stage ops 1-8 when (start && md_op in 1-4) || busy; this block SHALL expose busy without combinational dependence on inputs.

Reset
REQ-027 reset=1 at an edge SHALL set HI=0, LO=0, counter=0, pending=0, so busy=0 next cycle; md_out follows REQ-011.
REQ-028 reset mid-operation SHALL abort the op; HI/LO SHALL NOT receive the pending result.
REQ-029 reset SHALL take priority over any simultaneous op acceptance or completion.

Verification
REQ-030 mult A=0xFFFFFFFF, B=2, start=1 -> busy high exactly 5 cycles; then mfhi=0xFFFFFFFF, mflo=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-032 HI=0x11, LO=0x22, then div B=0 -> busy 10 cycles; after completion HI=0x11, LO=0x22.
REQ-033 mthi A=0x1234 with req=1 -> HI unchanged; same with req=0 -> mfhi returns 0x1234 next cycle.
REQ-034 mult started, reset asserted at busy cycle 3 -> busy=0 next cycle, HI=LO=0, no later result write.
REQ-035 mult in flight, mtlo/mult presented with start=1 at busy cycle 2 -> ignored; original product lands after 5 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit with fixed-latency busy window.
// Ports: clk, reset (sync, active-high), md_op/start/req/A/B (E-stage),
//        busy (registered), md_out (HI/LO read mux, combinational).
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op,
   input  logic        start,
   input  logic        req,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] md_out
);

   localparam int MAX_CYCLES =
      (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   logic [CW-1:0] count;
   logic [31:0]   hi;
   logic [31:0]   lo;
   logic [31:0]   pend_hi;
   logic [31:0]   pend_lo;

   logic          accept;
   logic [63:0]   prod_s;
   logic [63:0]   prod_u;
   logic [31:0]   quot_s;
   logic [31:0]   rem_s;
   logic [31:0]   quot_u;
   logic [31:0]   rem_u;
   logic          div_zero;
   logic          div_ovf;

   assign accept = start & ~req & ~busy;

   // The full result is computed at acceptance and parked until the
   // busy window expires, so HI/LO keep their old values meanwhile.
   always_comb begin
      prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      prod_u   = {32'd0, A} * {32'd0, B};
      div_zero = (B == 32'd0);
      div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
      quot_s   = 32'd0;
      rem_s    = 32'd0;
      quot_u   = 32'd0;
      rem_u    = 32'd0;
      if (div_ovf) begin
         quot_s = 32'h8000_0000;
      end else if (!div_zero) begin
         quot_s = $signed(A) / $signed(B);
         rem_s  = $signed(A) % $signed(B);
      end
      if (!div_zero) begin
         quot_u = A / B;
         rem_u  = A % B;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         busy    <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
      end else if (busy) begin
         // In-flight op cannot be cancelled or overwritten.
         count <= count - CW'(1);
         busy  <= (count != CW'(1));
         if (count == CW'(1)) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
      end else if (accept) begin
         case (md_op)
            OP_MULT: begin
               count <= CW'(MULT_CYCLES);
               busy  <= 1'b1;
               {pend_hi, pend_lo} <= prod_s;
            end
            OP_MULTU: begin
               count <= CW'(MULT_CYCLES);
               busy  <= 1'b1;
               {pend_hi, pend_lo} <= prod_u;
            end
            OP_DIV: begin
               count   <= CW'(DIV_CYCLES);
               busy    <= 1'b1;
               // Divide by zero writes back the current HI/LO.
               pend_hi <= div_zero ? hi : rem_s;
               pend_lo <= div_zero ? lo : quot_s;
            end
            OP_DIVU: begin
               count   <= CW'(DIV_CYCLES);
               busy    <= 1'b1;
               pend_hi <= div_zero ? hi : rem_u;
               pend_lo <= div_zero ? lo : quot_u;
            end
            OP_MTHI: hi <= A;
            OP_MTLO: lo <= A;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (md_op)
         OP_MFHI: md_out = hi;
         OP_MFLO: md_out = lo;
         default: md_out = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic model + literals.
// Drives directed vectors, compares busy/md_out every negedge.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  md_op;
   logic        start;
   logic        req;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] md_out;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [31:0] m_ph = 32'd0;
   logic [31:0] m_pl = 32'd0;
   int          m_rem = 0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .md_op(md_op), .start(start),
      .req(req), .A(A), .B(B), .busy(busy), .md_out(md_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Model: what the architecture says happens at one clock edge.
   task automatic model_edge();
      longint      p;
      longint      q;
      longint      r;
      if (reset) begin
         m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_rem = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) begin
            m_hi = m_ph;
            m_lo = m_pl;
         end
      end else if (start && !req) begin
         case (md_op)
            4'd1: begin
               p = longint'($signed(A)) * longint'($signed(B));
               m_ph = p[63:32]; m_pl = p[31:0]; m_rem = 5;
            end
            4'd2: begin
               p = longint'(A) * longint'(B);
               m_ph = p[63:32]; m_pl = p[31:0]; m_rem = 5;
            end
            4'd3, 4'd4: begin
               m_rem = 10;
               if (B == 0) begin
                  m_ph = m_hi; m_pl = m_lo;
               end else begin
                  if (md_op == 4'd3) begin
                     q = longint'($signed(A)) / longint'($signed(B));
                     r = longint'($signed(A)) % longint'($signed(B));
                  end else begin
                     q = longint'(A) / longint'(B);
                     r = longint'(A) % longint'(B);
                  end
                  m_pl = q[31:0]; m_ph = r[31:0];
               end
            end
            4'd7: m_hi = A;
            4'd8: m_lo = A;
            default: ;
         endcase
      end
   endtask

   function automatic logic [31:0] exp_out();
      if (md_op == 4'd5) return m_hi;
      if (md_op == 4'd6) return m_lo;
      return 32'd0;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {31'd0, busy}, {31'd0, (m_rem != 0)});
         chk("md_out", md_out, exp_out());
      end
   end

   task automatic step(input logic [3:0] op, input logic st,
                       input logic rq, input logic rs,
                       input logic [31:0] a, input logic [31:0] b);
      md_op = op; start = st; req = rq; reset = rs; A = a; B = b;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      step(4'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic read_hl(input string name, input logic [31:0] eh,
                          input logic [31:0] el);
      md_op = 4'd5; start = 1'b1; req = 1'b0; reset = 1'b0;
      #1;
      chk({name, "_hi"}, md_out, eh);
      md_op = 4'd6;
      #1;
      chk({name, "_lo"}, md_out, el);
      idle();
   endtask

   task automatic run_op(input string name, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_n);
      int cnt = 0;
      step(op, 1'b1, 1'b0, 1'b0, a, b);
      for (int i = 0; i < 50 && busy; i++) begin
         cnt++;
         idle();
      end
      chk({name, "_done"}, {31'd0, busy}, 32'd0);
      chk({name, "_cycles"}, 32'(cnt), 32'(exp_n));
   endtask

   initial begin
      int cnt;
      step(4'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      step(4'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      chk_en = 1'b1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      read_hl("rst", 32'd0, 32'd0);

      run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5);
      read_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5);
      read_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);
      run_op("mult_neg", 4'd1, 32'hFFFF_FFFD, 32'd5, 5);
      read_hl("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
      read_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu", 4'd4, 32'd7, 32'd2, 10);
      read_hl("divu", 32'd1, 32'd3);
      run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      read_hl("div_ovf", 32'd0, 32'h8000_0000);

      step(4'd7, 1'b1, 1'b0, 1'b0, 32'h11, 32'd0);
      step(4'd8, 1'b1, 1'b0, 1'b0, 32'h22, 32'd0);
      run_op("div0", 4'd3, 32'd99, 32'd0, 10);
      read_hl("div0", 32'h11, 32'h22);
      run_op("divu0", 4'd4, 32'd5, 32'd0, 10);
      read_hl("divu0", 32'h11, 32'h22);

      step(4'd7, 1'b1, 1'b1, 1'b0, 32'h1234, 32'd0);
      read_hl("mthi_req", 32'h11, 32'h22);
      step(4'd7, 1'b1, 1'b0, 1'b0, 32'h1234, 32'd0);
      read_hl("mthi", 32'h1234, 32'h22);

      step(4'd1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
      idle();
      idle();
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      step(4'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      read_hl("abort", 32'd0, 32'd0);
      for (int i = 0; i < 6; i++) idle();
      read_hl("abort_late", 32'd0, 32'd0);

      step(4'd7, 1'b1, 1'b0, 1'b0, 32'hAA, 32'd0);
      cnt = 0;
      step(4'd1, 1'b1, 1'b0, 1'b0, 32'd6, 32'd7);
      if (busy) cnt++;
      step(4'd8, 1'b1, 1'b0, 1'b0, 32'h55, 32'd0);
      if (busy) cnt++;
      step(4'd1, 1'b1, 1'b0, 1'b0, 32'd9, 32'd9);
      if (busy) cnt++;
      step(4'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
      if (busy) cnt++;
      for (int i = 0; i < 50 && busy; i++) begin
         idle();
         if (busy) cnt++;
      end
      chk("viol_cycles", 32'(cnt), 32'd5);
      read_hl("viol", 32'd0, 32'd42);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
